// File: rtl/nanov_ser_pkg.sv
// nanov_ser_pkg: shared constants and state type for the nanov serial frame transmitter.
//   FRAME_BITS : total serial frame length (b + a + op)
//   OP_W       : opcode field width
//   DATA_W     : operand field width
//   state_e    : transmitter FSM states
package nanov_ser_pkg;

  localparam int unsigned FRAME_BITS = 68;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StSettle
  } state_e;

endpackage

// File: rtl/nanov_ser_tx.sv
// nanov_ser_tx: serialises a {b, a, op} command into a 68-bit MSB-first bit stream for a
// serial core, then idles SETTLE_CYCLES cycles before signalling completion.
//
// Optional feature (macro NANOV_SER_CAPTURE_EN): sample the core's returned result bits
// o31_i / o0_i at the completion edge into res_o31 / res_o0, with res_valid pulsing alongside
// done. Without the macro the result ports are tied to 0 and o31_i / o0_i are ignored.
//
// Ports:
//   clk12MHz          : clock, all state changes on its rising edge
//   rstn              : asynchronous active-low reset
//   in_valid/in_ready : command handshake (ready exactly while idle)
//   in_op/in_a/in_b   : command fields
//   ser_o             : serial frame bit (low while idle or settling)
//   busy              : frame or settle period in progress
//   done              : one-cycle completion pulse
//   o31_i/o0_i        : result bits returned by the core
//   res_valid/res_o31/res_o0 : captured result
module nanov_ser_tx
  import nanov_ser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk12MHz,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              ser_o,
  output logic              busy,
  output logic              done,
  input  logic              o31_i,
  input  logic              o0_i,
  output logic              res_valid,
  output logic              res_o31,
  output logic              res_o0
);

  localparam logic [6:0] LastBit    = 7'(FRAME_BITS - 1);
  localparam logic [3:0] LastSettle = 4'(SETTLE_CYCLES - 1);

  state_e                  r_state;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [6:0]              r_bit_cnt;
  logic [3:0]              r_settle_cnt;
  logic                    r_ser;
  logic                    r_done;
  logic                    w_settle_last;

  assign w_settle_last = (r_state == StSettle) && (r_settle_cnt == LastSettle);

  // ser_o is registered: on the accept edge it already carries frame bit 0, and each later
  // SHIFT edge loads the next bit, so bit k is presented from edge k to edge k+1.
  always_ff @(posedge clk12MHz or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_settle_cnt <= '0;
      r_ser        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_shift   <= {in_b, in_a, in_op};
            r_ser     <= in_b[DATA_W-1];
            r_bit_cnt <= '0;
            r_state   <= StShift;
          end
        end
        StShift: begin
          if (r_bit_cnt == LastBit) begin
            r_ser        <= 1'b0;
            r_settle_cnt <= '0;
            r_state      <= StSettle;
          end else begin
            r_ser     <= r_shift[FRAME_BITS-2];
            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 7'd1;
          end
        end
        StSettle: begin
          if (w_settle_last) begin
            r_settle_cnt <= '0;
            r_bit_cnt    <= '0;
            r_done       <= 1'b1;
            r_state      <= StIdle;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready = (r_state == StIdle);
  assign busy     = (r_state != StIdle);
  assign ser_o    = r_ser;
  assign done     = r_done;

`ifdef NANOV_SER_CAPTURE_EN
  logic r_res_valid;
  logic r_res_o31;
  logic r_res_o0;

  // Result bits are sampled on the same edge that raises done and held until the next frame.
  always_ff @(posedge clk12MHz or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_res_o31   <= 1'b0;
      r_res_o0    <= 1'b0;
    end else begin
      r_res_valid <= w_settle_last;
      if (w_settle_last) begin
        r_res_o31 <= o31_i;
        r_res_o0  <= o0_i;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_o31   = r_res_o31;
  assign res_o0    = r_res_o0;
`else
  logic w_unused_res;
  assign w_unused_res = o31_i ^ o0_i;

  assign res_valid = 1'b0;
  assign res_o31   = 1'b0;
  assign res_o0    = 1'b0;
`endif

endmodule

// File: tb/tb_nanov_ser_tx.sv
// tb_nanov_ser_tx: randomized scoreboard bench for nanov_ser_tx. The stimulus side pushes the
// expected 68-bit frame ({b, a, op}) per command; a negedge monitor rebuilds the frame from
// ser_o as a receive chain, checks frame timing, and compares against the queue at done.
module tb_nanov_ser_tx;

  localparam int S     = 2;
  localparam int FRAME = 68;

  logic        clk12MHz = 1'b0;
  logic        rstn     = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op    = '0;
  logic [31:0] in_a     = '0;
  logic [31:0] in_b     = '0;
  logic        ser_o;
  logic        busy;
  logic        done;
  logic        o31_i    = 1'b0;
  logic        o0_i     = 1'b0;
  logic        res_valid;
  logic        res_o31;
  logic        res_o0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [67:0] q[$];

  nanov_ser_tx #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk12MHz (clk12MHz),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .ser_o    (ser_o),
    .busy     (busy),
    .done     (done),
    .o31_i    (o31_i),
    .o0_i     (o0_i),
    .res_valid(res_valid),
    .res_o31  (res_o31),
    .res_o0   (res_o0)
  );

  always #5 clk12MHz = ~clk12MHz;

  always @(posedge clk12MHz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core result bits wander randomly every cycle.
  initial begin
    forever begin
      @(posedge clk12MHz);
      #1;
      o31_i = 1'($urandom);
      o0_i  = 1'($urandom);
    end
  end

  // Monitor / scoreboard.
  int          e = -1;
  bit          armed = 1'b0;
  logic [67:0] chain = '0;
  logic        cap31 = 1'b0, cap0 = 1'b0;
  logic        held31 = 1'b0, held0 = 1'b0;

  always @(negedge clk12MHz) begin
    logic done_now;
    logic [67:0] exp_frame;
    done_now = 1'b0;
    if (!rstn) begin
      e      = -1;
      armed  = 1'b0;
      held31 = 1'b0;
      held0  = 1'b0;
      chk("rst_ser_o", ser_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", {res_valid, res_o31, res_o0}, 0);
    end else begin
      if (armed) begin
        e     = 0;
        armed = 1'b0;
        chain = '0;
      end else if (e >= 0) begin
        e++;
      end

      if (e < 0) begin
        chk("idle_ser_o", ser_o, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_in_ready", in_ready, 1);
      end else if (e < FRAME) begin
        chain = {chain[66:0], ser_o};
        chk("shift_busy", busy, 1);
        chk("shift_in_ready", in_ready, 0);
        chk("shift_done", done, 0);
      end else if (e < FRAME + S) begin
        chk("settle_ser_o", ser_o, 0);
        chk("settle_busy", busy, 1);
        chk("settle_in_ready", in_ready, 0);
        chk("settle_done", done, 0);
        if (e == FRAME + S - 1) begin
          cap31 = o31_i;
          cap0  = o0_i;
        end
      end else begin
        done_now = 1'b1;
        chk("done_pulse", done, 1);
        chk("done_in_ready", in_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_ser_o", ser_o, 0);
        chk("queue_has_entry", 68'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_frame = q.pop_front();
          chk("loopback_frame", chain, exp_frame);
        end
`ifdef NANOV_SER_CAPTURE_EN
        held31 = cap31;
        held0  = cap0;
`endif
        e = -1;
      end

`ifdef NANOV_SER_CAPTURE_EN
      chk("res_valid", res_valid, done_now);
      chk("res_bits", {res_o31, res_o0}, {held31, held0});
`else
      chk("res_tied_zero", {res_valid, res_o31, res_o0}, 0);
`endif
      if (in_valid && in_ready) armed = 1'b1;
    end
  end

  // Present a command and wait for its accept edge; returns at accept edge + 1.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [67:0] exp, input bit keep_valid, output int acc_cyc);
    bit ok;
    bit rdy;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    q.push_back(exp);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk12MHz);
      rdy = in_ready;
      @(posedge clk12MHz);
      ok = rdy;
    end
    if (!ok) begin
      $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
      $fatal(1, "accept timeout");
    end
    #1;
    acc_cyc = cyc;
    if (!keep_valid) begin
      in_valid = 1'b0;
      // Scramble fields while busy; the frame in flight must not notice.
      in_op = 4'($urandom);
      in_a  = $urandom;
      in_b  = $urandom;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk12MHz);
    #1;
    chk("queue_drained", 68'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, dummy;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [67:0] dropped;
    bit keep;

    repeat (3) @(posedge clk12MHz);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk12MHz);
    #1;

    // Directed frame with a hand-written expected bit pattern.
    send(4'hA, 32'h8000_0001, 32'h0000_0003, 68'h00000003_80000001_A, 1'b0, dummy);
    drain();

    // Back-to-back: valid held high across two commands.
    op = 4'($urandom); a = $urandom; b = $urandom;
    send(op, a, b, {b, a, op}, 1'b1, acc1);
    op = 4'($urandom); a = $urandom; b = $urandom;
    send(op, a, b, {b, a, op}, 1'b0, acc2);
    chk("b2b_accept_spacing", 68'(acc2 - acc1), 68'(FRAME + S + 1));
    drain();

    // Random commands with random gaps or back-to-back issue.
    for (int n = 0; n < 8; n++) begin
      op   = 4'($urandom);
      a    = $urandom;
      b    = $urandom;
      keep = (n != 7) && ($urandom_range(0, 1) == 1);
      send(op, a, b, {b, a, op}, keep, dummy);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk12MHz);
          #1;
        end
      end
    end
    drain();

    // Reset mid-frame after edge 30.
    op = 4'($urandom); a = $urandom; b = $urandom;
    send(op, a, b, {b, a, op}, 1'b0, dummy);
    repeat (30) @(posedge clk12MHz);
    #1;
    rstn = 1'b0;
    dropped = q.pop_back();
    #1;
    chk("midrst_ser_o", ser_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(posedge clk12MHz);
    #1;
    rstn = 1'b1;
    op = 4'($urandom); a = $urandom; b = $urandom;
    send(op, a, b, {b, a, op}, 1'b0, dummy);
    drain();

    repeat (4) @(posedge clk12MHz);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nanov_ser_tx.md
NANOV_SER_TX -- requirements
Module: nanov_ser_tx

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of idle cycles (1..15) held after the last frame bit before completion.
REQ-002 SHALL have port clk12MHz  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  command presented.
REQ-005 SHALL have port in_ready  output  1  command accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have ports in_op  input  4, in_a  input  32, in_b  input  32: command fields.
REQ-007 SHALL have port ser_o  output  1  serial bit stream driven into the core's serial input.
REQ-008 SHALL have port busy  output  1  frame or settle in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports o31_i  input  1, o0_i  input  1: result bits d[31] and d[0] returned from the core.
REQ-011 SHALL have ports res_valid  output  1, res_o31  output  1, res_o0  output  1: captured result.

Function
REQ-012 SHALL implement states IDLE, SHIFT and SETTLE.
REQ-013 in_ready SHALL be high exactly when the state is IDLE.
REQ-014 On accept, SHALL latch {in_b, in_a, in_op} into a 68-bit shift register and move to SHIFT.
REQ-015 Frame order SHALL be in_b[31] first down to in_b[0], then in_a[31..0], then in_op[3..0] last.
REQ-016 Numbering the accept edge as edge 0, ser_o SHALL carry frame bit k (k = 0..67) from edge k until edge k+1.
REQ-017 After edge 68, SHALL be in SETTLE with ser_o low; after edge 68+SETTLE_CYCLES, SHALL return to IDLE.
REQ-018 done SHALL be high for exactly the one cycle following edge 68+SETTLE_CYCLES.
REQ-019 in_ready SHALL be high in that same cycle, so an in_valid high at edge 69+SETTLE_CYCLES starts the next frame with no gap cycle.
REQ-020 ser_o SHALL be low in IDLE and in SETTLE.
REQ-021 busy SHALL be high in SHIFT and SETTLE.
REQ-022 The bit counter SHALL be 7 bits wide, count 0..67 in SHIFT, and never wrap.
REQ-023 The settle counter SHALL be 4 bits wide.
REQ-024 in_* changes while busy SHALL have no effect on the frame in progress.
REQ-025 in_valid SHALL be ignored outside IDLE.

Reset
REQ-026 rstn low SHALL immediately force IDLE, ser_o=0, busy=0, done=0, res_valid=0, res_o31=0, res_o0=0, both counters 0 and the shift register 0, including mid-frame.
REQ-027 A frame aborted by reset SHALL NOT produce done.
REQ-028 After rstn rises, in_ready SHALL be high in the first cycle.

Configuration
REQ-029 With macro NANOV_SER_CAPTURE_EN defined, SHALL sample o31_i and o0_i into res_o31 and res_o0 at edge 68+SETTLE_CYCLES.
REQ-030 With NANOV_SER_CAPTURE_EN defined, res_valid SHALL pulse coincident with done, and res_o31/res_o0 SHALL hold until the next capture.
REQ-031 Without NANOV_SER_CAPTURE_EN, the ports SHALL remain present, o31_i and o0_i SHALL be unused, and res_valid, res_o31 and res_o0 SHALL be tied to 0.

Structure
REQ-032 A shared package nanov_ser_pkg SHALL hold FRAME_BITS=68, OP_W=4, DATA_W=32 and the state enum type.
REQ-033 SHALL be a single module with no sub-modules; the shift register and counters are inline.

Verification
REQ-034 Frame content: op=4'hA, a=32'h8000_0001, b=32'h0000_0003, SETTLE_CYCLES=2 -> ser_o after edges 0..67 = 30x0,1,1 | 1,30x0,1 | 1,0,1,0; done high only after edge 70.
REQ-035 Loopback: drive ser_o into a model of the 68-bit receive chain -> at done, chain holds op=A, a=8000_0001, b=0000_0003 exactly.
REQ-036 Back-to-back: in_valid held high for two commands -> second accept at edge 71; no idle gap beyond SETTLE; in_ready low for edges 1..70 of each frame.
REQ-037 Reset mid-frame: rstn low after edge 30 -> ser_o=0, busy=0 immediately; no done; a new frame after release is correct from bit 0.
REQ-038 Capture (NANOV_SER_CAPTURE_EN): o31_i=1, o0_i=0 at edge 70 -> res_valid pulses with done; res_o31=1, res_o0=0, held through the next frame.
REQ-039 Without NANOV_SER_CAPTURE_EN, the same stimulus as REQ-038 -> res_valid, res_o31 and res_o0 stay 0.
